cus43_tile_pixel: RTL
=====================

Name: cus43_tile_pixel

Overview:
- Consumer end of the tilemap address generator.
- Captures tile attribute bytes from tile SRAM (RD) and bitplane bytes from the graphics ROM (GD) at the same fixed per-cell slots the address generator drives RA/GA for.
- Serialises both layers into 3-bit pens, applies per-layer fine X scroll, and priority-merges layer A over layer B into one pixel stream for the palette stage.

Parameters:
- TRANSPARENT_PEN, 3'd7, pen value treated as transparent in the layer merge.
- BG_COLOR, 8'h00, COLOR driven when both layers are transparent (DOT is then forced to TRANSPARENT_PEN).

Ports:
- CLK_6M  in  1  pixel clock; all state on rising edge.
- nRST  in  1  reset; asynchronous assert, active low, synchronous deassert outside block.
- nHSYNC  in  1  low holds cell counter at 0 (line alignment).
- FLIP  in  1  1 = shift LSB-first (horizontal flip).
- RD  in  8  tile SRAM data (attribute byte).
- GD  in  8  graphics ROM data (one bitplane byte).
- SCROLLA  in  3  layer A fine X scroll (0-7 pixel delay).
- SCROLLB  in  3  layer B fine X scroll.
- DOT  out  3  merged pen.
- COLOR  out  8  merged colour/attribute.
- LAYER  out  1  0 = A won, 1 = B won or background.
- CELL  out  3  current cell counter (slot phase, for bench/alignment).

Behaviour:
- Reset: all outputs 0, CELL = 0, all capture, shift and delay registers 0.
- Cell counter:
  - 3-bit, increments each CLK_6M and wraps 7 -> 0.
  - Forced to 0 on any clock where nHSYNC = 0.
- Capture slots, taken at a clock edge when CELL equals:
  - 0: attrA <- RD
  - 1: attrB <- RD
  - 2: p0A <- GD
  - 3: p0B <- GD
  - 4: p1A <- GD
  - 5: p1B <- GD
  - 6: p2A <- GD
  - 7: p2B <- GD
  - Captures go to staging registers only.
- Load:
  - On the edge where CELL = 7, both layers' staging (p2B from GD on that same edge) transfer to shift and attribute working registers.
  - The whole next cell then uses a stable attribute.
  - No load occurs while nHSYNC is held low.
- Shift:
  - Every other clock, each plane register shifts one bit: MSB out with FLIP = 0, LSB out with FLIP = 1, zero fill.
  - Pen = {p2, p1, p0} bits.
  - The load edge supplies pixel 0 directly; no shift on that edge.
- Fine scroll:
  - Per-layer 8-deep pen+attribute delay line.
  - Tap = SCROLLx; 0 = no added delay.
  - Sampled every clock, so a mid-line change takes effect on the next pixel.
- Merge, registered:
  - If penA != TRANSPARENT_PEN: A wins.
  - Else if penB != TRANSPARENT_PEN: B wins.
  - Else: background (DOT = TRANSPARENT_PEN, COLOR = BG_COLOR, LAYER = 1).
- Latency: pixel k (0-7) of a tile whose bytes were captured in cell N appears on DOT at load edge + k + 1 + SCROLLx clocks.
- Boundary cases:
  - nHSYNC low mid-cell: counter resets and partial staging is kept but overwritten by the next captures. Shift registers keep shifting (zero fill), so the output becomes pen 0 from layer A.
  - nRST mid-line: immediate clear; first valid pixels appear at load edge + 1 after release.
  - SCROLL = 7 with FLIP toggling: FLIP affects only the shift direction at shift time; the delay line is unaffected.

Optional Feature:
- Macro CUS43_PRIORITY_EN.
- Defined: attrB[7] = 1 makes an opaque layer-B pen win over an opaque layer-A pen. Otherwise the merge rule is unchanged.
- Undefined: attrB[7] is ignored; A always has priority; no extra logic.

Test Plan:
- Reset and count:
  - Stimulus: nRST low then high, nHSYNC high.
  - Response: all outputs 0; CELL counts 0..7 and wraps.
  - Stimulus: nHSYNC low for 3 clocks.
  - Response: CELL = 0 throughout.
- Basic serialise:
  - Stimulus: RD = 8'h25 at CELL 0; GD = 8'hFF, 8'h00, 8'h00 at the A plane slots (CELL 2/4/6). Layer B is all 7s (p0B = p1B = p2B = 8'hFF).
  - Response: after the load, 8 consecutive pixels show DOT = 3'd1, COLOR = 8'h25, LAYER = 0.
- Flip:
  - Stimulus: A p0 = 8'h80 with FLIP = 0, then FLIP = 1.
  - Response: pen 1 on the first pixel of the cell when FLIP = 0; on the last pixel when FLIP = 1. Pen 0 elsewhere.
- Fine scroll:
  - Stimulus: repeat the flip case with SCROLLA = 3.
  - Response: pen 1 appears exactly 3 clocks later than with SCROLLA = 0.
- Transparency and background:
  - Stimulus: all A planes 8'hFF (pen 7); B pen 5 with attrB = 8'h42.
  - Response: DOT = 5, COLOR = 8'h42, LAYER = 1.
  - Stimulus: B planes also 8'hFF.
  - Response: COLOR = BG_COLOR, DOT = 7.
- Priority (CUS43_PRIORITY_EN defined):
  - Stimulus: A pen 2, B pen 4, attrB = 8'h80.
  - Response: DOT = 4, LAYER = 1.
  - Stimulus: same with attrB = 8'h00.
  - Response: DOT = 2, LAYER = 0.

Source files
------------

// File: rtl/cus43_tile_pixel_if.sv
// cus43_tile_pixel_if: pixel-stage bus between the tile/ROM data path and the palette stage.
// Signals:
//   nHSYNC   low holds the cell counter at 0
//   FLIP     1 = serialise LSB-first
//   RD       tile SRAM attribute byte
//   GD       graphics ROM bitplane byte
//   SCROLLA  layer A fine X scroll (0-7)
//   SCROLLB  layer B fine X scroll (0-7)
//   DOT      merged pen
//   COLOR    merged colour/attribute
//   LAYER    0 = layer A won, 1 = layer B or background
//   CELL     current cell counter (slot phase)
// Modports: master drives the inputs and observes the pixel; slave is the pixel stage.
interface cus43_tile_pixel_if;
    logic       nHSYNC;
    logic       FLIP;
    logic [7:0] RD;
    logic [7:0] GD;
    logic [2:0] SCROLLA;
    logic [2:0] SCROLLB;
    logic [2:0] DOT;
    logic [7:0] COLOR;
    logic       LAYER;
    logic [2:0] CELL;
    modport master (
        output nHSYNC, FLIP, RD, GD, SCROLLA, SCROLLB,
        input  DOT, COLOR, LAYER, CELL
    );
    modport slave (
        input  nHSYNC, FLIP, RD, GD, SCROLLA, SCROLLB,
        output DOT, COLOR, LAYER, CELL
    );
endinterface

// File: rtl/cus43_tile_pixel.sv
// cus43_tile_pixel: captures tile attributes and bitplanes, serialises two layers, fine-scrolls and priority-merges them.
// Ports:
//   CLK_6M  pixel clock, all state on the rising edge
//   nRST    asynchronous active-low reset
//   bus     cus43_tile_pixel_if.slave (nHSYNC, FLIP, RD, GD, SCROLLA, SCROLLB in; DOT, COLOR, LAYER, CELL out)
// Parameters: TRANSPARENT_PEN (pen ignored by the merge), BG_COLOR (colour when both layers are transparent).
// Build option: define CUS43_PRIORITY_EN to let attrB[7] put an opaque layer-B pen above an opaque layer-A pen.
module cus43_tile_pixel #(
    parameter logic [2:0] TRANSPARENT_PEN = 3'd7,
    parameter logic [7:0] BG_COLOR        = 8'h00
) (
    input logic               CLK_6M,
    input logic               nRST,
    cus43_tile_pixel_if.slave bus
);
    logic [2:0]  r_cell;
    logic [7:0]  r_stg_attr_a, r_stg_attr_b;
    logic [7:0]  r_stg_a [3];
    logic [7:0]  r_stg_b [2];
    logic [7:0]  r_sh_a [3];
    logic [7:0]  r_sh_b [3];
    logic [7:0]  r_attr_a, r_attr_b;
    logic [10:0] r_dl_a [7];
    logic [10:0] r_dl_b [7];
    logic [2:0]  r_dot;
    logic [7:0]  r_color;
    logic        r_layer;

    logic        w_load;
    logic [2:0]  w_pen_a, w_pen_b;
    logic [10:0] w_line_a [8];
    logic [10:0] w_line_b [8];
    logic [10:0] w_tap_a, w_tap_b;
    logic        w_a_op, w_b_op, w_b_win;

    // The last slot of a cell hands the whole tile to the shifters; p2B comes straight off GD.
    assign w_load = bus.nHSYNC && (r_cell == 3'd7);

    always_ff @(posedge CLK_6M or negedge nRST) begin
        if (!nRST) r_cell <= 3'd0;
        else       r_cell <= bus.nHSYNC ? r_cell + 3'd1 : 3'd0;
    end

    always_ff @(posedge CLK_6M or negedge nRST) begin
        if (!nRST) begin
            r_stg_attr_a <= 8'h00;
            r_stg_attr_b <= 8'h00;
            for (int i = 0; i < 3; i++) r_stg_a[i] <= 8'h00;
            for (int i = 0; i < 2; i++) r_stg_b[i] <= 8'h00;
        end else begin
            if (r_cell == 3'd0) r_stg_attr_a <= bus.RD;
            if (r_cell == 3'd1) r_stg_attr_b <= bus.RD;
            if (r_cell == 3'd2) r_stg_a[0]   <= bus.GD;
            if (r_cell == 3'd3) r_stg_b[0]   <= bus.GD;
            if (r_cell == 3'd4) r_stg_a[1]   <= bus.GD;
            if (r_cell == 3'd5) r_stg_b[1]   <= bus.GD;
            if (r_cell == 3'd6) r_stg_a[2]   <= bus.GD;
        end
    end

    // The load edge presents pixel 0 directly; every other edge shifts with zero fill.
    always_ff @(posedge CLK_6M or negedge nRST) begin
        if (!nRST) begin
            r_attr_a <= 8'h00;
            r_attr_b <= 8'h00;
            for (int i = 0; i < 3; i++) begin
                r_sh_a[i] <= 8'h00;
                r_sh_b[i] <= 8'h00;
            end
        end else if (w_load) begin
            r_attr_a  <= r_stg_attr_a;
            r_attr_b  <= r_stg_attr_b;
            r_sh_a[0] <= r_stg_a[0];
            r_sh_a[1] <= r_stg_a[1];
            r_sh_a[2] <= r_stg_a[2];
            r_sh_b[0] <= r_stg_b[0];
            r_sh_b[1] <= r_stg_b[1];
            r_sh_b[2] <= bus.GD;
        end else begin
            for (int i = 0; i < 3; i++) begin
                r_sh_a[i] <= bus.FLIP ? r_sh_a[i] >> 1 : r_sh_a[i] << 1;
                r_sh_b[i] <= bus.FLIP ? r_sh_b[i] >> 1 : r_sh_b[i] << 1;
            end
        end
    end

    assign w_pen_a = bus.FLIP ? {r_sh_a[2][0], r_sh_a[1][0], r_sh_a[0][0]}
                              : {r_sh_a[2][7], r_sh_a[1][7], r_sh_a[0][7]};
    assign w_pen_b = bus.FLIP ? {r_sh_b[2][0], r_sh_b[1][0], r_sh_b[0][0]}
                              : {r_sh_b[2][7], r_sh_b[1][7], r_sh_b[0][7]};

    // Tap 0 is the live shifter output; tap n is that output n clocks ago.
    always_comb begin
        w_line_a[0] = {r_attr_a, w_pen_a};
        w_line_b[0] = {r_attr_b, w_pen_b};
        for (int i = 1; i < 8; i++) begin
            w_line_a[i] = r_dl_a[i-1];
            w_line_b[i] = r_dl_b[i-1];
        end
    end

    always_ff @(posedge CLK_6M or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < 7; i++) begin
                r_dl_a[i] <= 11'd0;
                r_dl_b[i] <= 11'd0;
            end
        end else begin
            r_dl_a[0] <= w_line_a[0];
            r_dl_b[0] <= w_line_b[0];
            for (int i = 1; i < 7; i++) begin
                r_dl_a[i] <= r_dl_a[i-1];
                r_dl_b[i] <= r_dl_b[i-1];
            end
        end
    end

    assign w_tap_a = w_line_a[bus.SCROLLA];
    assign w_tap_b = w_line_b[bus.SCROLLB];
    assign w_a_op  = w_tap_a[2:0] != TRANSPARENT_PEN;
    assign w_b_op  = w_tap_b[2:0] != TRANSPARENT_PEN;
`ifdef CUS43_PRIORITY_EN
    assign w_b_win = w_b_op && (!w_a_op || w_tap_b[10]);
`else
    assign w_b_win = w_b_op && !w_a_op;
`endif

    always_ff @(posedge CLK_6M or negedge nRST) begin
        if (!nRST) begin
            r_dot   <= 3'd0;
            r_color <= 8'h00;
            r_layer <= 1'b0;
        end else begin
            r_dot   <= w_b_win ? w_tap_b[2:0]  : w_a_op ? w_tap_a[2:0]  : TRANSPARENT_PEN;
            r_color <= w_b_win ? w_tap_b[10:3] : w_a_op ? w_tap_a[10:3] : BG_COLOR;
            r_layer <= w_b_win || !w_a_op;
        end
    end

    assign bus.DOT   = r_dot;
    assign bus.COLOR = r_color;
    assign bus.LAYER = r_layer;
    assign bus.CELL  = r_cell;
endmodule
